pe_loader: RTL and testbench

- Feeder/collector that sits between the global buffer and one PE. It drives the PE's load and compute side of the interface.
- It fetches KERNEL_SIZE² weights and ACT_SIZE² activations from a 1-cycle-latency source memory and streams them into the PE with load_en_wght/load_en_act.
- It then issues one start pulse per output row (ACT_SIZE-KERNEL_SIZE+1 rows) and captures pe_out on each compute_done as a result beat.
- A watchdog flags a PE that never answers.

---
 rtl/pe_loader.sv | 172 +++++++++++++++++
 tb/tb_pe_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_loader.sv
// pe_loader: feeds one PE with a weight and an activation tile from a
// 1-cycle-latency source memory, then runs one compute pass per output row
// and returns each row's psum as a result beat. A watchdog aborts the job
// if the PE stops answering.
module pe_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int SRC_ADDR_WIDTH = 10,
    parameter int KERNEL_SIZE    = 3,
    parameter int ACT_SIZE       = 5,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic [SRC_ADDR_WIDTH-1:0] w_base,
    input  logic [SRC_ADDR_WIDTH-1:0] a_base,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     src_rd_data,
    output logic                      load_en_wght,
    output logic                      load_en_act,
    output logic [DATA_WIDTH-1:0]     filt_in,
    output logic [DATA_WIDTH-1:0]     act_in,
    output logic                      start,
    input  logic [DATA_WIDTH-1:0]     pe_out,
    input  logic                      compute_done,
    input  logic                      load_done,
    output logic                      res_valid,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [2:0]                res_idx
);

    localparam int N_W      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int N_A      = ACT_SIZE * ACT_SIZE;
    localparam int N_MAX    = (N_A > N_W) ? N_A : N_W;
    localparam int CNT_W    = $clog2(N_MAX + 2);
    localparam int WD_W     = $clog2(TIMEOUT + 1);
    localparam int LAST_ROW = ACT_SIZE - KERNEL_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        W_STREAM,
        W_WAIT,
        A_STREAM,
        A_WAIT,
        RUN_START,
        RUN_WAIT
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt;
    logic [WD_W-1:0]           wd;
    logic [SRC_ADDR_WIDTH-1:0] w_base_q, a_base_q;
    logic [2:0]                row;
    logic                      wait_st;
    logic                      wd_exp;
    logic                      timeout;

    // Next-state decode plus the combinational read port and status outputs.
    // A stream state lasts N+1 cycles: N reads, then one more cycle so the
    // last read word lands in the output register before the wait begins.
    always_comb begin
        state_n   = state;
        src_rd_en = 1'b0;
        src_addr  = '0;
        timeout   = 1'b0;
        busy      = (state != IDLE);
        start     = (state == RUN_START);
        wait_st   = (state == W_WAIT) || (state == A_WAIT) || (state == RUN_WAIT);
        wd_exp    = wait_st && (wd == WD_W'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (go) state_n = W_STREAM;
            end
            W_STREAM: begin
                if (cnt < CNT_W'(N_W)) begin
                    src_rd_en = 1'b1;
                    src_addr  = w_base_q + SRC_ADDR_WIDTH'(cnt);
                end
                if (cnt == CNT_W'(N_W)) state_n = W_WAIT;
            end
            W_WAIT: begin
                if (load_done) state_n = A_STREAM;
                else if (wd_exp) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            A_STREAM: begin
                if (cnt < CNT_W'(N_A)) begin
                    src_rd_en = 1'b1;
                    src_addr  = a_base_q + SRC_ADDR_WIDTH'(cnt);
                end
                if (cnt == CNT_W'(N_A)) state_n = A_WAIT;
            end
            A_WAIT: begin
                if (load_done) state_n = RUN_START;
                else if (wd_exp) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            RUN_START: begin
                state_n = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (compute_done) state_n = (row == 3'(LAST_ROW)) ? IDLE : RUN_START;
                else if (wd_exp) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, counters, and the registered PE/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            w_base_q     <= '0;
            a_base_q     <= '0;
            row          <= '0;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            filt_in      <= '0;
            act_in       <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_idx      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_n;

            if (state_n != state) cnt <= '0;
            else if ((state == W_STREAM) || (state == A_STREAM)) cnt <= cnt + 1'b1;

            if (state_n != state) wd <= '0;
            else if (wait_st) wd <= wd + 1'b1;

            if ((state == IDLE) && go) begin
                w_base_q <= w_base;
                a_base_q <= a_base;
                row      <= '0;
            end

            // Read data for word i is present when cnt == i+1.
            load_en_wght <= (state == W_STREAM) && (cnt == CNT_W'(1));
            load_en_act  <= (state == A_STREAM) && (cnt == CNT_W'(1));
            if ((state == W_STREAM) && (cnt != '0)) filt_in <= src_rd_data;
            if ((state == A_STREAM) && (cnt != '0)) act_in  <= src_rd_data;

            res_valid <= 1'b0;
            done      <= 1'b0;
            err       <= timeout;
            if ((state == RUN_WAIT) && compute_done) begin
                res_valid <= 1'b1;
                res_data  <= pe_out;
                res_idx   <= row;
                row       <= row + 1'b1;
                done      <= (row == 3'(LAST_ROW));
            end
        end
    end

endmodule

// File: tb/tb_pe_loader.sv
// tb_pe_loader: directed bench for pe_loader with a source-memory model and
// a hand-timed PE model driven from a single stimulus sequence.
module tb_pe_loader;

    logic        clk = 1'b0;
    logic        reset, go;
    logic [9:0]  w_base, a_base;
    logic        busy, done, err;
    logic        src_rd_en;
    logic [9:0]  src_addr;
    logic [15:0] src_rd_data = '0;
    logic        load_en_wght, load_en_act;
    logic [15:0] filt_in, act_in;
    logic        start;
    logic [15:0] pe_out;
    logic        compute_done, load_done;
    logic        res_valid;
    logic [15:0] res_data;
    logic [2:0]  res_idx;

    logic [15:0] mem [0:1023];
    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int sc0;

    pe_loader #(
        .DATA_WIDTH(16),
        .SRC_ADDR_WIDTH(10),
        .KERNEL_SIZE(3),
        .ACT_SIZE(5),
        .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .w_base(w_base), .a_base(a_base),
        .busy(busy), .done(done), .err(err),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
        .load_en_wght(load_en_wght), .load_en_act(load_en_act),
        .filt_in(filt_in), .act_in(act_in), .start(start),
        .pe_out(pe_out), .compute_done(compute_done), .load_done(load_done),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    // Source memory with one cycle of read latency.
    always @(posedge clk) src_rd_data <= src_rd_en ? mem[src_addr] : 16'h0;

    // Running count of start pulses.
    always @(posedge clk) if (start === 1'b1) start_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic nc;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at the negedge of a RUN_START cycle; drives three rows.
    task automatic run_rows(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2);
        logic [15:0] pv;
        chk("start_r0", 32'(start), 1);
        for (int r = 0; r < 3; r++) begin
            pv = (r == 0) ? p0 : ((r == 1) ? p1 : p2);
            nc;
            chk("start_low_w1", 32'(start), 0);
            chk("res_valid_w1", 32'(res_valid), 0);
            nc;
            chk("start_low_w2", 32'(start), 0);
            compute_done = 1'b1;
            pe_out = pv;
            nc;
            compute_done = 1'b0;
            pe_out = '0;
            chk("res_valid", 32'(res_valid), 1);
            chk("res_data", 32'(res_data), 32'(pv));
            chk("res_idx", 32'(res_idx), 32'(r));
            chk("done_row", 32'(done), (r == 2) ? 1 : 0);
            chk("busy_row", 32'(busy), (r < 2) ? 1 : 0);
            chk("start_next", 32'(start), (r < 2) ? 1 : 0);
            chk("err_row", 32'(err), 0);
            if (r == 2) go = 1'b0;
        end
        nc;
        chk("done_once", 32'(done), 0);
        chk("res_valid_end", 32'(res_valid), 0);
        chk("busy_end", 32'(busy), 0);
        chk("rd_en_end", 32'(src_rd_en), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 9; i++) mem[i] = 16'(i + 1);
        for (int i = 0; i < 25; i++) mem[100 + i] = 16'(i + 10);
        mem[10'h3FE] = 16'h0055;
        mem[10'h3FF] = 16'h0066;

        reset = 1'b1; go = 1'b0; load_done = 1'b0; compute_done = 1'b0;
        pe_out = '0; w_base = '0; a_base = '0;
        repeat (2) nc;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rd_en", 32'(src_rd_en), 0);
        chk("rst_addr", 32'(src_addr), 0);
        chk("rst_lew", 32'(load_en_wght), 0);
        chk("rst_lea", 32'(load_en_act), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_filt", 32'(filt_in), 0);
        reset = 1'b0;
        nc;
        chk("idle_busy", 32'(busy), 0);

        // Full job: weights 1..9 at 0, activations 10..34 at 100.
        sc0 = start_cnt;
        go = 1'b1; w_base = 10'd0; a_base = 10'd100;
        for (int k = 0; k <= 10; k++) begin
            nc;
            if (k == 0) go = 1'b0;
            chk("w_busy", 32'(busy), 1);
            chk("w_rd_en", 32'(src_rd_en), (k <= 8) ? 1 : 0);
            if (k <= 8) chk("w_addr", 32'(src_addr), 32'(k));
            chk("w_lew", 32'(load_en_wght), (k == 2) ? 1 : 0);
            chk("w_lea", 32'(load_en_act), 0);
            if (k >= 2) chk("w_filt", 32'(filt_in), 32'(k - 1));
            chk("w_start", 32'(start), 0);
            if (k == 10) load_done = 1'b1;
        end
        for (int k = 0; k <= 28; k++) begin
            nc;
            if (k == 0) load_done = 1'b0;
            chk("a_rd_en", 32'(src_rd_en), (k <= 24) ? 1 : 0);
            if (k <= 24) chk("a_addr", 32'(src_addr), 32'(100 + k));
            chk("a_lea", 32'(load_en_act), (k == 2) ? 1 : 0);
            chk("a_lew", 32'(load_en_wght), 0);
            if (k >= 2 && k <= 26) chk("a_act", 32'(act_in), 32'(k + 8));
            chk("a_filt_hold", 32'(filt_in), 9);
            chk("a_start", 32'(start), 0);
            if (k == 28) load_done = 1'b1;
        end
        nc;
        load_done = 1'b0;
        chk("act_hold", 32'(act_in), 34);
        run_rows(16'd100, 16'd200, 16'd300);
        chk("start_count", 32'(start_cnt - sc0), 3);

        // Watchdog: row 1 never completes.
        sc0 = start_cnt;
        go = 1'b1; w_base = 10'd0; a_base = 10'd100;
        nc; go = 1'b0;
        repeat (10) nc;
        load_done = 1'b1;
        nc; load_done = 1'b0;
        repeat (26) nc;
        load_done = 1'b1;
        nc; load_done = 1'b0;
        chk("to_start0", 32'(start), 1);
        nc;
        nc;
        compute_done = 1'b1; pe_out = 16'd111;
        nc;
        compute_done = 1'b0; pe_out = '0;
        chk("to_res0", 32'(res_data), 111);
        chk("to_start1", 32'(start), 1);
        nc;
        repeat (254) nc;
        chk("to_err_early", 32'(err), 0);
        chk("to_busy_early", 32'(busy), 1);
        nc;
        chk("to_err", 32'(err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_done", 32'(done), 0);
        chk("to_start", 32'(start), 0);
        nc;
        chk("to_err_pulse", 32'(err), 0);
        chk("to_start_count", 32'(start_cnt - sc0), 2);

        // Reset at the 4th activation word, then a wrapping weight stream.
        go = 1'b1; w_base = 10'd0; a_base = 10'd100;
        nc; go = 1'b0;
        repeat (10) nc;
        load_done = 1'b1;
        nc; load_done = 1'b0;
        repeat (5) nc;
        chk("mid_act3", 32'(act_in), 13);
        reset = 1'b1;
        nc;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_act", 32'(act_in), 0);
        chk("mid_filt", 32'(filt_in), 0);
        chk("mid_rd_en", 32'(src_rd_en), 0);
        chk("mid_addr", 32'(src_addr), 0);
        reset = 1'b0;
        go = 1'b1; w_base = 10'h3FE; a_base = 10'd0;
        nc; go = 1'b0;
        chk("wrap_a0", 32'(src_addr), 32'h3FE);
        nc;
        chk("wrap_a1", 32'(src_addr), 32'h3FF);
        nc;
        chk("wrap_a2", 32'(src_addr), 32'h000);
        chk("wrap_lew", 32'(load_en_wght), 1);
        chk("wrap_f0", 32'(filt_in), 32'h55);
        nc;
        chk("wrap_a3", 32'(src_addr), 32'h001);
        chk("wrap_f1", 32'(filt_in), 32'h66);
        nc;
        chk("wrap_f2", 32'(filt_in), 1);
        reset = 1'b1;
        nc;
        reset = 1'b0;

        // go held through the job, spurious compute_done in W_WAIT.
        sc0 = start_cnt;
        go = 1'b1; w_base = 10'd0; a_base = 10'd100;
        repeat (11) nc;
        compute_done = 1'b1;
        nc;
        compute_done = 1'b0;
        chk("sp_res_valid", 32'(res_valid), 0);
        chk("sp_busy", 32'(busy), 1);
        load_done = 1'b1;
        nc;
        load_done = 1'b0;
        chk("sp_a_addr", 32'(src_addr), 100);
        repeat (26) nc;
        load_done = 1'b1;
        nc;
        load_done = 1'b0;
        run_rows(16'd7, 16'd8, 16'd9);
        chk("sp_start_count", 32'(start_cnt - sc0), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
